// File: rtl/rat_nway_pkg.sv
// Shared sizing constants and the field-select macro for the N-way register alias table.
// Defaults here match the rat_nway parameter defaults.
`ifndef RAT_NWAY_PKG_SV
`define RAT_NWAY_PKG_SV

`define SEL(vec, w, k) vec[(k)*(w) +: (w)]

package rat_nway_pkg;
    localparam int WAYS_DEF    = 2;
    localparam int ARF_IDX_DEF = 5;
    localparam int PRF_IDX_DEF = 6;
    localparam int ARF_SZ      = 2**ARF_IDX_DEF;
    localparam int PRF_SZ      = 2**PRF_IDX_DEF;
endpackage

`endif

// File: rtl/rat_free_pick.sv
// Cascaded lowest-set-bit pickers: each requesting way, in way order, takes the
// lowest remaining free PRF; non-requesting ways consume nothing.
module rat_free_pick
    import rat_nway_pkg::*;
#(
    parameter int WAYS    = WAYS_DEF,
    parameter int PRF_IDX = PRF_IDX_DEF
) (
    input  logic [2**PRF_IDX-1:0]   free_vec,
    input  logic [WAYS-1:0]         req,
    output logic [WAYS*PRF_IDX-1:0] idx,
    output logic [WAYS-1:0]         valid
);
    localparam int PRF_N = 2**PRF_IDX;

    // Priority-encode the remaining vector per way, then strike the chosen bit.
    always_comb begin : pick_c
        logic [PRF_N-1:0] rem_s;
        rem_s = free_vec;
        idx   = '0;
        valid = '0;
        for (int k = 0; k < WAYS; k++) begin
            for (int i = PRF_N - 1; i >= 0; i--) begin
                if (req[k] && rem_s[i]) begin
                    `SEL(idx, PRF_IDX, k) = PRF_IDX'(i);
                    valid[k] = 1'b1;
                end else begin
                    valid[k] = valid[k];
                end
            end
            if (valid[k]) begin
                rem_s[`SEL(idx, PRF_IDX, k)] = 1'b0;
            end else begin
                rem_s = rem_s;
            end
        end
    end
endmodule

// File: rtl/rat_nway.sv
// N-way RAT with retirement map, speculative free list and flush recovery.
// Optional: define RAT_RETIRE_BYPASS_EN to let retire-freed PRFs be allocated in the same cycle.
module rat_nway
    import rat_nway_pkg::*;
#(
    parameter int WAYS    = WAYS_DEF,
    parameter int ARF_IDX = ARF_IDX_DEF,
    parameter int PRF_IDX = PRF_IDX_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [WAYS-1:0]         issue,
    input  logic [WAYS*ARF_IDX-1:0] rega_idx_in,
    input  logic [WAYS*ARF_IDX-1:0] regb_idx_in,
    input  logic [WAYS*ARF_IDX-1:0] dest_idx_in,
    output logic [WAYS*PRF_IDX-1:0] prega_idx_out,
    output logic [WAYS*PRF_IDX-1:0] pregb_idx_out,
    output logic [WAYS*PRF_IDX-1:0] pdest_idx_out,
    output logic [WAYS*PRF_IDX-1:0] pdest_old_out,
    output logic                    issue_ack,
    output logic [PRF_IDX:0]        free_cnt,
    input  logic [WAYS-1:0]         retire,
    input  logic [WAYS*ARF_IDX-1:0] retire_dest_idx_in,
    input  logic [WAYS*PRF_IDX-1:0] retire_pdest_idx_in
);
    localparam int ARF_N = 2**ARF_IDX;
    localparam int PRF_N = 2**PRF_IDX;

    logic [PRF_IDX-1:0] rat_r      [ARF_N];
    logic [PRF_IDX-1:0] rrat_r     [ARF_N];
    logic [PRF_N-1:0]   free_r;
    logic [PRF_IDX:0]   free_cnt_r;

    logic [PRF_IDX-1:0] rrat_nxt_s [ARF_N];
    logic [PRF_IDX-1:0] rat_nxt_s  [ARF_N];
    logic [PRF_N-1:0]   ret_free_s;
    logic [PRF_IDX:0]   ret_cnt_s;
    logic [PRF_N-1:0]   pick_vec_s;
    logic [PRF_IDX+1:0] free_avail_s;
    logic [WAYS-1:0]    alloc_s;
    logic [PRF_IDX:0]   alloc_cnt_s;
    logic [WAYS*PRF_IDX-1:0] pick_idx_s;
    logic [WAYS-1:0]    pick_valid_s;
    logic               issue_ack_s;
    logic [PRF_N-1:0]   free_nxt_s;
    logic [PRF_IDX:0]   cnt_nxt_s;
    logic [PRF_N-1:0]   flush_free_s;
    logic [PRF_IDX:0]   flush_cnt_s;

    // Apply retires in way order so a same-ARF later way frees the earlier way's PRF.
    always_comb begin
        rrat_nxt_s = rrat_r;
        ret_free_s = '0;
        ret_cnt_s  = '0;
        for (int k = 0; k < WAYS; k++) begin
            if (retire[k] && (`SEL(retire_dest_idx_in, ARF_IDX, k) != '0)) begin
                ret_free_s[rrat_nxt_s[`SEL(retire_dest_idx_in, ARF_IDX, k)]] = 1'b1;
                rrat_nxt_s[`SEL(retire_dest_idx_in, ARF_IDX, k)] = `SEL(retire_pdest_idx_in, PRF_IDX, k);
            end else begin
                ret_free_s = ret_free_s;
            end
        end
        ret_free_s[0] = 1'b0;
        for (int i = 0; i < PRF_N; i++) begin
            ret_cnt_s = ret_cnt_s + {{PRF_IDX{1'b0}}, ret_free_s[i]};
        end
    end

`ifdef RAT_RETIRE_BYPASS_EN
    assign pick_vec_s   = free_r | ret_free_s;
    assign free_avail_s = {1'b0, free_cnt_r} + {1'b0, ret_cnt_s};
`else
    assign pick_vec_s   = free_r;
    assign free_avail_s = {1'b0, free_cnt_r};
`endif

    // Allocating ways and their count; dest 0 is pinned and never allocates.
    always_comb begin
        alloc_s     = '0;
        alloc_cnt_s = '0;
        for (int k = 0; k < WAYS; k++) begin
            alloc_s[k]  = issue[k] && (`SEL(dest_idx_in, ARF_IDX, k) != '0);
            alloc_cnt_s = alloc_cnt_s + {{PRF_IDX{1'b0}}, alloc_s[k]};
        end
    end

    rat_free_pick #(
        .WAYS    (WAYS),
        .PRF_IDX (PRF_IDX)
    ) u_pick (
        .free_vec (pick_vec_s),
        .req      (alloc_s),
        .idx      (pick_idx_s),
        .valid    (pick_valid_s)
    );

    assign issue_ack_s = (|issue) && !flush
                       && (free_avail_s >= {1'b0, alloc_cnt_s})
                       && (&(pick_valid_s | ~alloc_s));

    // Rename lookups with intra-group bypass: the highest earlier matching way wins.
    always_comb begin
        prega_idx_out = '0;
        pregb_idx_out = '0;
        pdest_idx_out = '0;
        pdest_old_out = '0;
        for (int k = 0; k < WAYS; k++) begin
            if (issue[k]) begin
                `SEL(prega_idx_out, PRF_IDX, k) = rat_r[`SEL(rega_idx_in, ARF_IDX, k)];
                `SEL(pregb_idx_out, PRF_IDX, k) = rat_r[`SEL(regb_idx_in, ARF_IDX, k)];
                `SEL(pdest_old_out, PRF_IDX, k) = alloc_s[k] ? rat_r[`SEL(dest_idx_in, ARF_IDX, k)] : '0;
                `SEL(pdest_idx_out, PRF_IDX, k) = alloc_s[k] ? `SEL(pick_idx_s, PRF_IDX, k) : '0;
                for (int j = 0; j < k; j++) begin
                    `SEL(prega_idx_out, PRF_IDX, k) =
                        (alloc_s[j] && (`SEL(dest_idx_in, ARF_IDX, j) == `SEL(rega_idx_in, ARF_IDX, k)))
                        ? `SEL(pick_idx_s, PRF_IDX, j) : `SEL(prega_idx_out, PRF_IDX, k);
                    `SEL(pregb_idx_out, PRF_IDX, k) =
                        (alloc_s[j] && (`SEL(dest_idx_in, ARF_IDX, j) == `SEL(regb_idx_in, ARF_IDX, k)))
                        ? `SEL(pick_idx_s, PRF_IDX, j) : `SEL(pregb_idx_out, PRF_IDX, k);
                    `SEL(pdest_old_out, PRF_IDX, k) =
                        (alloc_s[k] && alloc_s[j] && (`SEL(dest_idx_in, ARF_IDX, j) == `SEL(dest_idx_in, ARF_IDX, k)))
                        ? `SEL(pick_idx_s, PRF_IDX, j) : `SEL(pdest_old_out, PRF_IDX, k);
                end
            end else begin
                pdest_idx_out = pdest_idx_out;
            end
        end
    end

    // Normal-cycle next state: retire frees merge in, accepted allocations are claimed.
    always_comb begin
        rat_nxt_s  = rat_r;
        free_nxt_s = free_r | ret_free_s;
        cnt_nxt_s  = free_cnt_r + ret_cnt_s;
        for (int k = 0; k < WAYS; k++) begin
            if (issue_ack_s && alloc_s[k]) begin
                rat_nxt_s[`SEL(dest_idx_in, ARF_IDX, k)] = `SEL(pick_idx_s, PRF_IDX, k);
                free_nxt_s[`SEL(pick_idx_s, PRF_IDX, k)] = 1'b0;
            end else begin
                free_nxt_s = free_nxt_s;
            end
        end
        cnt_nxt_s = issue_ack_s ? (cnt_nxt_s - alloc_cnt_s) : cnt_nxt_s;
    end

    // Flush recovery: free list becomes every PRF the post-retire RRAT does not reference.
    always_comb begin
        flush_free_s = '1;
        flush_cnt_s  = '0;
        for (int a = 0; a < ARF_N; a++) begin
            flush_free_s[rrat_nxt_s[a]] = 1'b0;
        end
        flush_free_s[0] = 1'b0;
        for (int i = 0; i < PRF_N; i++) begin
            flush_cnt_s = flush_cnt_s + {{PRF_IDX{1'b0}}, flush_free_s[i]};
        end
    end

    // State registers: reset > flush > retire/issue.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int a = 0; a < ARF_N; a++) begin
                rat_r[a]  <= PRF_IDX'(a);
                rrat_r[a] <= PRF_IDX'(a);
            end
            free_r     <= {{(PRF_N-ARF_N){1'b1}}, {ARF_N{1'b0}}};
            free_cnt_r <= (PRF_IDX+1)'(PRF_N - ARF_N);
        end else if (flush) begin
            rat_r      <= rrat_nxt_s;
            rrat_r     <= rrat_nxt_s;
            free_r     <= flush_free_s;
            free_cnt_r <= flush_cnt_s;
        end else begin
            rat_r      <= rat_nxt_s;
            rrat_r     <= rrat_nxt_s;
            free_r     <= free_nxt_s;
            free_cnt_r <= cnt_nxt_s;
        end
    end

    assign issue_ack = issue_ack_s;
    assign free_cnt  = free_cnt_r;
endmodule

// File: tb/tb_rat_nway.sv
// Directed self-checking bench for rat_nway at default parameters (2 ways, 32 ARF, 64 PRF).
module tb_rat_nway;
    localparam int WAYS = 2;
    localparam int AI   = 5;
    localparam int PI   = 6;

    logic                 clk;
    logic                 reset;
    logic                 flush;
    logic [WAYS-1:0]      issue;
    logic [WAYS*AI-1:0]   rega_idx_in, regb_idx_in, dest_idx_in;
    logic [WAYS*PI-1:0]   prega_idx_out, pregb_idx_out, pdest_idx_out, pdest_old_out;
    logic                 issue_ack;
    logic [PI:0]          free_cnt;
    logic [WAYS-1:0]      retire;
    logic [WAYS*AI-1:0]   retire_dest_idx_in;
    logic [WAYS*PI-1:0]   retire_pdest_idx_in;

    int n_cmp = 0;
    int n_bad = 0;

    rat_nway dut (
        .clk                 (clk),
        .reset               (reset),
        .flush               (flush),
        .issue               (issue),
        .rega_idx_in         (rega_idx_in),
        .regb_idx_in         (regb_idx_in),
        .dest_idx_in         (dest_idx_in),
        .prega_idx_out       (prega_idx_out),
        .pregb_idx_out       (pregb_idx_out),
        .pdest_idx_out       (pdest_idx_out),
        .pdest_old_out       (pdest_old_out),
        .issue_ack           (issue_ack),
        .free_cnt            (free_cnt),
        .retire              (retire),
        .retire_dest_idx_in  (retire_dest_idx_in),
        .retire_pdest_idx_in (retire_pdest_idx_in)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pa(input int k);  return int'(prega_idx_out[k*PI +: PI]); endfunction
    function automatic int pb(input int k);  return int'(pregb_idx_out[k*PI +: PI]); endfunction
    function automatic int pd(input int k);  return int'(pdest_idx_out[k*PI +: PI]); endfunction
    function automatic int po(input int k);  return int'(pdest_old_out[k*PI +: PI]); endfunction

    task automatic clr();
        issue = '0; rega_idx_in = '0; regb_idx_in = '0; dest_idx_in = '0;
        retire = '0; retire_dest_idx_in = '0; retire_pdest_idx_in = '0;
    endtask

    task automatic set_way(input int k, input int a, input int b, input int d);
        issue[k] = 1'b1;
        rega_idx_in[k*AI +: AI] = AI'(a);
        regb_idx_in[k*AI +: AI] = AI'(b);
        dest_idx_in[k*AI +: AI] = AI'(d);
    endtask

    task automatic set_ret(input int k, input int d, input int p);
        retire[k] = 1'b1;
        retire_dest_idx_in[k*AI +: AI]  = AI'(d);
        retire_pdest_idx_in[k*PI +: PI] = PI'(p);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; flush = 1'b0; clr();
        step();
        reset = 1'b1;
    endtask

    task automatic fill_groups(input int n, input int d0, input int d1);
        for (int g = 0; g < n; g++) begin
            clr(); set_way(0, 0, 0, d0); set_way(1, 0, 0, d1);
            step();
        end
        clr();
    endtask

    initial begin
        clk = 1'b0; reset = 1'b0; flush = 1'b0; clr();
        step(); step();
        check_eq("rst_ack",   int'(issue_ack), 0);
        check_eq("rst_pdest", int'(pdest_idx_out), 0);
        check_eq("rst_old",   int'(pdest_old_out), 0);
        check_eq("rst_prega", int'(prega_idx_out), 0);
        check_eq("rst_cnt",   int'(free_cnt), 32);
        reset = 1'b1;

        // Basic 2-way rename with source bypass
        set_way(0, 15, 14, 4); set_way(1, 4, 2, 5); #2;
        check_eq("a_ack", int'(issue_ack), 1);
        check_eq("a_pd0", pd(0), 32);
        check_eq("a_pd1", pd(1), 33);
        check_eq("a_pa0", pa(0), 15);
        check_eq("a_pb0", pb(0), 14);
        check_eq("a_pa1", pa(1), 32);
        check_eq("a_pb1", pb(1), 2);
        check_eq("a_po0", po(0), 4);
        check_eq("a_po1", po(1), 5);
        step(); clr();
        check_eq("a_cnt", int'(free_cnt), 30);

        // Same-dest group, then same-ARF double retire
        do_reset();
        set_way(0, 0, 0, 1); set_way(1, 1, 0, 1); #2;
        check_eq("b_pd0", pd(0), 32);
        check_eq("b_pd1", pd(1), 33);
        check_eq("b_po0", po(0), 1);
        check_eq("b_po1", po(1), 32);
        check_eq("b_pa1", pa(1), 32);
        step(); clr();
        check_eq("b_cnt", int'(free_cnt), 30);
        set_way(0, 1, 0, 0); set_ret(0, 1, 32); set_ret(1, 1, 33); #2;
        check_eq("b_rat1", pa(0), 33);
        check_eq("b_ack0", int'(issue_ack), 1);
        check_eq("b_pdz",  pd(0), 0);
        step(); clr();
        check_eq("b_cnt2", int'(free_cnt), 32);
        set_way(0, 0, 0, 3); set_way(1, 0, 0, 4); #2;
        check_eq("b_reuse0", pd(0), 1);
        check_eq("b_reuse1", pd(1), 32);
        step(); clr();

        // Dest 0 on way 0 allocates nothing; retire to ARF 0 is a no-op
        do_reset();
        set_way(0, 7, 0, 0); set_way(1, 0, 0, 3); #2;
        check_eq("c_pd0", pd(0), 0);
        check_eq("c_po0", po(0), 0);
        check_eq("c_pa0", pa(0), 7);
        check_eq("c_pd1", pd(1), 32);
        check_eq("c_po1", po(1), 3);
        step(); clr();
        check_eq("c_cnt", int'(free_cnt), 31);
        set_ret(0, 0, 5); step(); clr();
        check_eq("c_cnt0", int'(free_cnt), 31);

        // Exhaust the free list, then a rejected group leaves state alone
        do_reset();
        for (int g = 0; g < 16; g++) begin
            clr(); set_way(0, 0, 0, 6); set_way(1, 0, 0, 7); #2;
            check_eq("d_ack", int'(issue_ack), 1);
            check_eq("d_pd0", pd(0), 32 + 2*g);
            check_eq("d_pd1", pd(1), 33 + 2*g);
            step();
        end
        clr();
        check_eq("d_cnt", int'(free_cnt), 0);
        set_way(0, 0, 0, 8); set_way(1, 0, 0, 9); #2;
        check_eq("d_rej", int'(issue_ack), 0);
        step(); clr();
        check_eq("d_cnt2", int'(free_cnt), 0);
        set_way(0, 8, 7, 0); set_way(1, 6, 0, 0); #2;
        check_eq("d_rat8", pa(0), 8);
        check_eq("d_rat7", pb(0), 63);
        check_eq("d_rat6", pa(1), 62);
        step(); clr();

        // One free PRF plus a same-cycle retire freeing PRF 7
        do_reset();
        fill_groups(15, 6, 7);
        set_way(0, 0, 0, 6); step(); clr();
        check_eq("e_cnt1", int'(free_cnt), 1);
        set_ret(0, 7, 33); set_way(0, 0, 0, 10); set_way(1, 0, 0, 11); #2;
`ifdef RAT_RETIRE_BYPASS_EN
        check_eq("e_ack", int'(issue_ack), 1);
        check_eq("e_pd0", pd(0), 7);
        check_eq("e_pd1", pd(1), 63);
        step(); clr();
`else
        check_eq("e_ack", int'(issue_ack), 0);
        step(); clr();
        check_eq("e_cnt2", int'(free_cnt), 2);
        set_way(0, 0, 0, 10); set_way(1, 0, 0, 11); #2;
        check_eq("e_ack2", int'(issue_ack), 1);
        check_eq("e_pd0", pd(0), 7);
        check_eq("e_pd1", pd(1), 63);
        step(); clr();
`endif
        check_eq("e_cnt0", int'(free_cnt), 0);

        // Flush recovery with retires applied in the same cycle
        do_reset();
        fill_groups(5, 2, 3);
        check_eq("f_cnt22", int'(free_cnt), 22);
        set_ret(0, 2, 32); set_ret(1, 3, 33); step(); clr();
        check_eq("f_cnt24", int'(free_cnt), 24);
        set_ret(0, 2, 34); set_ret(1, 3, 35); set_way(0, 0, 0, 9); flush = 1'b1; #2;
        check_eq("f_ack", int'(issue_ack), 0);
        step(); flush = 1'b0; clr();
        check_eq("f_cnt", int'(free_cnt), 32);
        set_way(0, 2, 3, 5); set_way(1, 9, 0, 0); #2;
        check_eq("f_rat2", pa(0), 34);
        check_eq("f_rat3", pb(0), 35);
        check_eq("f_rat9", pa(1), 9);
        check_eq("f_pd0",  pd(0), 2);
        check_eq("f_po0",  po(0), 5);
        step(); clr();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
